// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stages: state names derived from the valid bits,
// occupancy width and the packed bundle widths each stage instance is built with.
package pipe_pkg;

    localparam int OCC_W = 2;

    // instruction(32) + pc(32)
    localparam int IF_ID_W  = 64;
    // instruction(32) + pc(32) + rs1/rs2 data(64) + imm(32) + control(16)
    localparam int ID_EX_W  = 176;
    // alu result(32) + store data(32) + rd(5) + control(11)
    localparam int EX_MEM_W = 80;
    // writeback data(32) + rd(5) + control(3)
    localparam int MEM_WB_W = 40;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    function automatic logic [OCC_W-1:0] occupancy(input stage_state_e s);
        case (s)
            EMPTY:   return OCC_W'(0);
            ONE:     return OCC_W'(1);
            FULL:    return OCC_W'(2);
            default: return OCC_W'(0);
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: main payload register plus optional skid entry, valid/ready both sides.
// Latency: 1 cycle from accept to out_valid on an empty stage; sustains 1 transfer per cycle.
// Backpressure: SKID=1 gives a registered in_ready (skid absorbs one beat); SKID=0 passes out_ready through.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int          WIDTH           = 32,
    parameter int unsigned SKID            = 1,
    parameter int unsigned ZERO_ON_INVALID = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             stall,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] count
);

    stage_state_e     state_q;
    stage_state_e     state_nxt;
    logic             main_v;
    logic             skid_v;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_d;
    logic             acc;
    logic             dlv;
    logic             load_main;
    logic             load_skid;
    logic             main_from_skid;
    logic             clear;

    assign acc   = in_valid & in_ready;
    assign dlv   = out_valid & out_ready;
    assign count = occupancy(state_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Stall needs no branch of its own: it already forces acc and dlv low.
    always_comb begin
        state_nxt      = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        clear          = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
            clear     = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_nxt = ONE;
                        load_main = 1'b1;
                    end
                end
                ONE: begin
                    if (acc && dlv) begin
                        load_main = 1'b1;
                    end else if (dlv) begin
                        state_nxt = EMPTY;
                    end else if (acc && SKID != 0) begin
                        state_nxt = FULL;
                        load_skid = 1'b1;
                    end
                end
                FULL: begin
                    if (dlv) begin
                        state_nxt      = ONE;
                        main_from_skid = 1'b1;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                    clear     = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        main_v    = (state_q != EMPTY);
        skid_v    = (state_q == FULL);
        out_valid = main_v & ~stall & ~flush;
        if (SKID != 0) begin
            in_ready = ~skid_v & ~stall & ~flush;
        end else begin
            in_ready = (~main_v | out_ready) & ~stall & ~flush;
        end
        out_data = main_d;
        if (!out_valid && ZERO_ON_INVALID != 0) begin
            out_data = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_d <= '0;
        end else if (clear) begin
            main_d <= '0;
        end else if (load_main) begin
            main_d <= in_data;
        end else if (main_from_skid) begin
            main_d <= skid_d;
        end
    end

    if (SKID != 0) begin : g_skid
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                skid_d <= '0;
            end else if (clear) begin
                skid_d <= '0;
            end else if (load_skid) begin
                skid_d <= in_data;
            end
        end
    end else begin : g_no_skid
        assign skid_d = '0;
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            assert (count <= OCC_W'(2));
            assert (!skid_v || main_v);
            assert (SKID != 0 || !skid_v);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Drives one SKID=1 and one SKID=0 stage with the same directed stimulus; a queue model
// per stage is compared every cycle, and literal expectations pin the key scenarios.
module tb_pipe_stage_elastic;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        stall = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = 32'h0;

    logic        in_ready1, out_valid1, in_ready0, out_valid0;
    logic [31:0] out_data1, out_data0;
    logic [1:0]  count1, count0;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] q1[$];
    logic [31:0] q0[$];

    always #5 clk = ~clk;

    pipe_stage_elastic #(.WIDTH(32), .SKID(1), .ZERO_ON_INVALID(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .count(count1)
    );

    pipe_stage_elastic #(.WIDTH(32), .SKID(0), .ZERO_ON_INVALID(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .count(count0)
    );

    // Capacity 2 accepts whenever not full; capacity 1 only when empty or draining this cycle.
    function automatic bit exp_rdy(int sz, int cap);
        if (stall || flush) return 1'b0;
        if (cap == 2) return sz < 2;
        return (sz == 0) || out_ready;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1.delete();
            q0.delete();
        end else begin
            bit rdy1, rdy0, ov1, ov0;
            rdy1 = exp_rdy(q1.size(), 2);
            rdy0 = exp_rdy(q0.size(), 1);
            ov1  = (q1.size() > 0) && !stall && !flush;
            ov0  = (q0.size() > 0) && !stall && !flush;
            if (flush) begin
                q1.delete();
                q0.delete();
            end else begin
                if (ov1 && out_ready) void'(q1.pop_front());
                if (in_valid && rdy1) q1.push_back(in_data);
                if (ov0 && out_ready) void'(q0.pop_front());
                if (in_valid && rdy0) q0.push_back(in_data);
            end
        end
    end

    task automatic cmp(input string nm, input int sz, input logic [31:0] head, input int cap,
                       input logic rdy, input logic ov, input logic [31:0] od, input logic [1:0] cnt);
        logic        e_ov;
        logic [31:0] e_od;
        logic        e_rdy;
        e_ov  = (sz > 0) && !stall && !flush;
        e_od  = e_ov ? head : 32'h0;
        e_rdy = exp_rdy(sz, cap);
        n_chk++;
        if (ov !== e_ov || od !== e_od || rdy !== e_rdy || cnt !== 2'(sz)) begin
            n_err++;
            $display("FAIL %s @%0t: got v=%0b d=%h rdy=%0b cnt=%0d, want v=%0b d=%h rdy=%0b cnt=%0d",
                     nm, $time, ov, od, rdy, cnt, e_ov, e_od, e_rdy, sz);
        end
    endtask

    always @(negedge clk) begin
        cmp("model_skid1", q1.size(), (q1.size() > 0) ? q1[0] : 32'h0, 2,
            in_ready1, out_valid1, out_data1, count1);
        cmp("model_skid0", q0.size(), (q0.size() > 0) ? q0[0] : 32'h0, 1,
            in_ready0, out_valid0, out_data0, count0);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with a valid beat waiting upstream
        rst_n = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid1), 32'd0);
        chk("rst_out_data",  out_data1, 32'd0);
        chk("rst_count",     32'(count1), 32'd0);
        chk("rst_in_ready",  32'(in_ready1), 32'd1);
        chk("rst_in_ready0", 32'(in_ready0), 32'd1);
        in_valid = 1'b0;
        tick();

        // Streaming 1..100, one per cycle, first visible one cycle after acceptance
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            in_data = 32'(i);
            tick();
            chk("stream_v1", 32'(out_valid1), 32'd1);
            chk("stream_d1", out_data1, 32'(i));
            chk("stream_v0", 32'(out_valid0), 32'd1);
            chk("stream_d0", out_data0, 32'(i));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain_cnt1", 32'(count1), 32'd0);
        chk("stream_drain_cnt0", 32'(count0), 32'd0);

        // Backpressure: 5 and 6 stack up in the SKID=1 stage
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd5;
        tick();
        in_data = 32'd6;
        tick();
        in_valid = 1'b0;
        #1;
        chk("bp_count",    32'(count1), 32'd2);
        chk("bp_in_ready", 32'(in_ready1), 32'd0);
        chk("bp_hold5",    out_data1, 32'd5);
        chk("bp_count0",   32'(count0), 32'd1);
        tick();
        chk("bp_hold5_again", out_data1, 32'd5);
        out_ready = 1'b1;
        #1;
        chk("bp_deliver5",   out_data1, 32'd5);
        chk("bp_rdy_during5", 32'(in_ready1), 32'd0);
        tick();
        chk("bp_deliver6",   out_data1, 32'd6);
        chk("bp_rdy_after5", 32'(in_ready1), 32'd1);
        tick();
        chk("bp_empty_v", 32'(out_valid1), 32'd0);

        // Flush while FULL drops 7, 8 and the 9 offered in the flush cycle
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd7;
        tick();
        in_data = 32'd8;
        tick();
        chk("fl_full", 32'(count1), 32'd2);
        flush = 1'b1; in_data = 32'd9;
        #1;
        chk("fl_in_ready", 32'(in_ready1), 32'd0);
        chk("fl_out_valid", 32'(out_valid1), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("fl_count", 32'(count1), 32'd0);
        chk("fl_out_data", out_data1, 32'd0);
        chk("fl_count0", 32'(count0), 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("fl_no_emit", 32'(out_valid1), 32'd0);
        end

        // Stall freezes a held 0x55 for three cycles
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55;
        tick();
        in_valid = 1'b0; stall = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("st_out_valid", 32'(out_valid1), 32'd0);
            chk("st_in_ready",  32'(in_ready1), 32'd0);
            chk("st_count",     32'(count1), 32'd1);
            @(posedge clk);
        end
        #1;
        stall = 1'b0;
        #1;
        chk("st_release_v", 32'(out_valid1), 32'd1);
        chk("st_release_d", out_data1, 32'h55);
        tick();
        chk("st_once_v", 32'(out_valid1), 32'd0);
        chk("st_once_cnt", 32'(count1), 32'd0);

        // Asynchronous reset between edges while FULL
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd7;
        tick();
        in_data = 32'd8;
        tick();
        in_valid = 1'b0;
        chk("ar_full", 32'(count1), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 32'(out_valid1), 32'd0);
        chk("ar_count",     32'(count1), 32'd0);
        chk("ar_out_data",  out_data1, 32'd0);
        chk("ar_count0",    32'(count0), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_after_v", 32'(out_valid1), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Generic, parametrised pipeline stage register, successor to the fixed per-stage IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Carries an opaque WIDTH-bit payload, which is the packed stage bundle (instruction, pc, id, control, ...).
- Uses a valid/ready handshake in place of a global stall: backpressure is local and no bubble is lost.
- An optional skid entry gives a registered in_ready, so ready paths do not chain combinationally across stages.
- Keeps the existing flush and stall semantics; adds asynchronous active-low reset.

Parameters:
- WIDTH, 32: payload width in bits.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- ZERO_ON_INVALID, 1: 1 = out_data is driven to 0 whenever out_valid=0; 0 = out_data shows the main entry regardless.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all held entries.
- stall  in  1  external freeze; blocks all transfers this cycle.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  payload presented downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  payload to downstream.
- count  out  2  occupancy, 0..2.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Storage:
  - main entry: main_v, main_d.
  - skid entry: skid_v, skid_d; present only when SKID=1.
- Reset (rst_n=0, asynchronous):
  - main_v=skid_v=0; main_d=skid_d=0.
  - Outputs: out_valid=0, out_data=0, count=0.
  - in_ready=1 once rst_n is deasserted, unless stall is high.
  - Reset asserted mid-transfer discards all entries; no partial transfer completes.
- Transfer conditions:
  - acc = in_valid & in_ready.
  - dlv = out_valid & out_ready.
  - Both take effect at the rising edge.
- Output and ready equations:
  - out_valid = main_v & !stall & !flush.
  - SKID=1: in_ready = !skid_v & !stall & !flush. skid_v is a flop, so the only combinational terms are stall and flush.
  - SKID=0: in_ready = (!main_v | out_ready) & !stall & !flush.
- States (derived from the valid bits): EMPTY (main_v=0), ONE (main_v=1, skid_v=0), FULL (main_v=1, skid_v=1; SKID=1 only).
  - EMPTY, acc: -> ONE, main_d<=in_data.
  - ONE, acc & dlv: -> ONE, main_d<=in_data. Zero-bubble throughput.
  - ONE, dlv only: -> EMPTY.
  - ONE, acc only: SKID=1 -> FULL, skid_d<=in_data. SKID=0 cannot occur, because in_ready=0.
  - FULL, dlv: -> ONE, main_d<=skid_d. acc is impossible, since in_ready=0.
  - FULL, no dlv: hold.
- Ordering: strict FIFO. The skid entry is never presented before the main entry.
- Flush:
  - Highest priority after reset.
  - Next state EMPTY, data registers cleared to 0.
  - The in_data arriving that cycle is dropped; flush forces in_ready=0, so the upstream sees no accept.
  - flush and stall together behave as flush.
- Stall:
  - Freezes state and data; in_ready=0 and out_valid=0 for that cycle.
  - Contents reappear unchanged the cycle after stall drops.
- out_data:
  - When out_valid=1: main_d.
  - When out_valid=0: 0 if ZERO_ON_INVALID=1, else main_d. This gives the same nop-zeroing convention as the current stage registers.
- count = main_v + skid_v, registered with the state, and unaffected by stall. Never exceeds 1 when SKID=0.
- Protocol rules:
  - Upstream must hold in_data stable while in_valid=1 and in_ready=0.
  - The block guarantees out_data stable while out_valid=1 and out_ready=0.
- Latency: 1 cycle from acceptance to out_valid on an empty stage. Sustained throughput is 1 per cycle with both SKID settings.
- Assertions (simulation only): count<=2; skid_v implies main_v; when SKID=0, skid_v is never set.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding: EMPTY=2'd0, ONE=2'd1, FULL=2'd2, derived for debug and assertions.
  - occupancy width constant OCC_W=2.
  - stage bundle widths, so each stage instantiates with WIDTH = IF_ID_W / ID_EX_W / EX_MEM_W / MEM_WB_W.
- No sub-module; the skid entry is too small to split out.
- Companion wrapper pipe_chain (DEPTH instances in series) is a separate later block.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 and in_data=32'hDEADBEEF, then release -> out_valid=0, out_data=0, count=0, in_ready=1 in the first cycle after release.
- Streaming: in_valid=1 with out_ready=1 constant, data 1,2,3,...,100 -> out_data 1..100 in order, one per cycle, first at +1 cycle, no bubbles (SKID=0 and SKID=1).
- Backpressure (SKID=1): send A=5, B=6 while out_ready=0 -> count=2, in_ready=0, out_data=5 held. Raise out_ready -> 5, then 6 on consecutive cycles; in_ready returns to 1 one cycle after 5 is delivered.
- Flush in FULL: entries 7,8 held, pulse flush with in_valid=1 and in_data=9 -> count=0 next cycle, out_valid=0, out_data=0, 9 never emitted.
- Stall: entry 0x55 held, stall=1 for 3 cycles with out_ready=1 -> out_valid=0 and in_ready=0 throughout, count unchanged. Drop stall -> 0x55 delivered once.
- Async reset mid-traffic: assert rst_n=0 between clock edges while FULL -> out_valid and count go to 0 immediately, without waiting for a clock edge.
